// File: rtl/dma_mem_rd_pack_if.sv
// Bundle of the request, memory-read and AXI-Stream signals of dma_mem_rd_pack.
// QICK_DMA_RD_TKEEP_EN adds m_axis_tkeep_o.
interface dma_mem_rd_pack_if #(
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 16,
  parameter int DMA_DW = 64
);
  logic              dma_req_i;
  logic              dma_ack_o;
  logic [MEM_AW-1:0] dma_addr_i;
  logic [MEM_AW-1:0] dma_len_i;
  logic              busy_o;
  logic              mem_en_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [MEM_DW-1:0] mem_dt_i;
  logic              m_axis_tready_i;
  logic              m_axis_tvalid_o;
  logic [DMA_DW-1:0] m_axis_tdata_o;
  logic              m_axis_tlast_o;
`ifdef QICK_DMA_RD_TKEEP_EN
  logic [DMA_DW/8-1:0] m_axis_tkeep_o;

  modport master (
    input  dma_req_i, dma_addr_i, dma_len_i, mem_dt_i, m_axis_tready_i,
    output dma_ack_o, busy_o, mem_en_o, mem_addr_o,
           m_axis_tvalid_o, m_axis_tdata_o, m_axis_tlast_o, m_axis_tkeep_o
  );
  modport slave (
    output dma_req_i, dma_addr_i, dma_len_i, mem_dt_i, m_axis_tready_i,
    input  dma_ack_o, busy_o, mem_en_o, mem_addr_o,
           m_axis_tvalid_o, m_axis_tdata_o, m_axis_tlast_o, m_axis_tkeep_o
  );
`else
  modport master (
    input  dma_req_i, dma_addr_i, dma_len_i, mem_dt_i, m_axis_tready_i,
    output dma_ack_o, busy_o, mem_en_o, mem_addr_o,
           m_axis_tvalid_o, m_axis_tdata_o, m_axis_tlast_o
  );
  modport slave (
    output dma_req_i, dma_addr_i, dma_len_i, mem_dt_i, m_axis_tready_i,
    input  dma_ack_o, busy_o, mem_en_o, mem_addr_o,
           m_axis_tvalid_o, m_axis_tdata_o, m_axis_tlast_o
  );
`endif
endinterface

// File: rtl/dma_mem_rd_pack.sv
// DMA read engine: streams memory words into packed AXI-Stream beats with credit-based issue.
// Optional byte-enable output when QICK_DMA_RD_TKEEP_EN is defined.
//
// state   | meaning
// ST_IDLE | waiting for dma_req_i, ack low
// ST_RUN  | issuing reads and emitting beats until tlast is accepted
// ST_END  | ack high, waiting for dma_req_i to fall
module dma_mem_rd_pack #(
  parameter int MEM_AW      = 16,
  parameter int MEM_DW      = 16,
  parameter int DMA_DW      = 64,
  parameter int MEM_LATENCY = 3
) (
  input logic clk_i,
  input logic rst_i,
  dma_mem_rd_pack_if.master bus
);
  localparam int RATIO      = DMA_DW / MEM_DW;
  localparam int LW         = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int FIFO_DEPTH = MEM_LATENCY + RATIO + 1;
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int CW         = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_END} state_t;
  state_t state, state_nxt;

  logic                   latch;
  logic [MEM_AW-1:0]      addr_q, issue_left, pack_left;
  logic [MEM_LATENCY-1:0] sr;
  logic [CW-1:0]          inflight, fifo_cnt;
  logic [MEM_DW-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]          lane;
  logic [DMA_DW-1:0]      acc, beat_data, tdata_q;
  logic                   tvalid_q, tlast_q;

  logic              issue, in_vld, fifo_empty, word_avail, last_word, beat_end;
  logic              out_free, consume, push, pop;
  logic [MEM_DW-1:0] word;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    case (state)
      ST_IDLE: if (bus.dma_req_i) begin
        latch     = 1'b1;
        state_nxt = (bus.dma_len_i != '0) ? ST_RUN : ST_END;
      end
      ST_RUN:  if (tvalid_q && bus.m_axis_tready_i && tlast_q) state_nxt = ST_END;
      ST_END:  if (!bus.dma_req_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Credit covers reads in flight plus words parked in the FIFO, so returns can never overflow it.
  assign issue = (state == ST_RUN) && (issue_left != '0) &&
                 (({1'b0, inflight} + {1'b0, fifo_cnt}) < (CW+1)'(FIFO_DEPTH));

  assign in_vld     = sr[MEM_LATENCY-1];
  assign fifo_empty = (fifo_cnt == '0);
  assign word_avail = !fifo_empty || in_vld;
  // Fall-through: with an empty FIFO the returning word goes straight to the packer.
  assign word       = fifo_empty ? bus.mem_dt_i : fifo_mem[rd_ptr];
  assign last_word  = (pack_left == MEM_AW'(1));
  assign beat_end   = (lane == LW'(RATIO - 1)) || last_word;
  assign out_free   = !tvalid_q || bus.m_axis_tready_i;
  assign consume    = word_avail && (!beat_end || out_free);
  assign pop        = consume && !fifo_empty;
  assign push       = in_vld && !(consume && fifo_empty);

  always_comb begin
    beat_data = acc;
    beat_data[lane*MEM_DW +: MEM_DW] = word;
  end

`ifdef QICK_DMA_RD_TKEEP_EN
  localparam int BPL = MEM_DW / 8;
  logic [DMA_DW/8-1:0] keep_nxt, tkeep_q;

  always_comb begin
    keep_nxt = '0;
    for (int k = 0; k < RATIO; k++)
      if (k <= int'(lane)) keep_nxt[k*BPL +: BPL] = '1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                   tkeep_q <= '0;
    else if (consume && beat_end) tkeep_q <= keep_nxt;
  end

  assign bus.m_axis_tkeep_o = tkeep_q;
`endif

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_dt_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      issue_left <= '0;
      pack_left  <= '0;
      sr         <= '0;
      inflight   <= '0;
      fifo_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lane       <= '0;
      acc        <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      if (latch) begin
        addr_q     <= bus.dma_addr_i;
        issue_left <= bus.dma_len_i;
      end else if (issue) begin
        addr_q     <= addr_q + MEM_AW'(1);
        issue_left <= issue_left - MEM_AW'(1);
      end

      sr       <= (sr << 1) | MEM_LATENCY'(issue);
      inflight <= inflight + CW'(issue) - CW'(in_vld);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);

      if (latch)        pack_left <= bus.dma_len_i;
      else if (consume) pack_left <= pack_left - MEM_AW'(1);

      if (consume && beat_end) begin
        acc      <= '0;
        lane     <= '0;
        tdata_q  <= beat_data;
        tvalid_q <= 1'b1;
        tlast_q  <= last_word;
      end else begin
        if (consume) begin
          acc  <= beat_data;
          lane <= lane + LW'(1);
        end
        if (bus.m_axis_tready_i) tvalid_q <= 1'b0;
      end
    end
  end

  assign bus.dma_ack_o       = (state == ST_END);
  assign bus.busy_o          = (state == ST_RUN);
  assign bus.mem_en_o        = issue;
  assign bus.mem_addr_o      = addr_q;
  assign bus.m_axis_tvalid_o = tvalid_q;
  assign bus.m_axis_tdata_o  = tdata_q;
  assign bus.m_axis_tlast_o  = tlast_q;
endmodule
